// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: writeback front end for the RV32I register file write port.
// Merges the single-cycle ALU result with a small FIFO of long-latency
// results. It issues one registered write per cycle and answers
// pending-write queries for hazard detection.
// Optional build macro WB_STARVE_GUARD_EN: while the macro is defined, a FIFO
// head that has waited STARVE_LIMIT cycles takes the write port from the ALU,
// and the alu_stall output tells the ALU to hold its result.
module reg_wb_arbiter #(
  parameter int XLEN         = 32,
  parameter int DEPTH        = 2
`ifdef WB_STARVE_GUARD_EN
  ,
  parameter int STARVE_LIMIT = 4
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  input  logic [4:0]               alu_rd,
  input  logic [XLEN-1:0]          alu_data,
  input  logic                     lsu_valid,
  output logic                     lsu_ready,
  input  logic [4:0]               lsu_rd,
  input  logic [XLEN-1:0]          lsu_data,
  output logic [4:0]               rd_addr,
  output logic [XLEN-1:0]          rd_data,
  output logic                     reg_write,
  input  logic [4:0]               chk_addr,
  output logic                     chk_busy,
  output logic [$clog2(DEPTH):0]   pend_count
`ifdef WB_STARVE_GUARD_EN
  ,
  output logic                     alu_stall
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Slot storage. A live bit is set only when the slot is occupied and its
  // entry has not been killed by a younger ALU write.
  logic [4:0]      ent_rd   [DEPTH];
  logic [XLEN-1:0] ent_data [DEPTH];
  logic [DEPTH-1:0] ent_live, live_next, kill_mask;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;

  logic fifo_empty, push, pop, alu_issue, stall, head_live;

  assign fifo_empty = (count == '0);
  assign lsu_ready  = (count < CW'(DEPTH));
  assign push       = lsu_valid && lsu_ready && (lsu_rd != 5'd0);
  assign alu_issue  = alu_valid && (alu_rd != 5'd0) && !stall;
  assign pop        = !fifo_empty && !alu_issue;
  assign head_live  = ent_live[rd_ptr];
  assign pend_count = count;

`ifdef WB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_cnt;

  assign stall     = !fifo_empty && (starve_cnt >= SW'(STARVE_LIMIT));
  assign alu_stall = stall;

  // Count consecutive cycles a head sits in the FIFO without being popped.
  always_ff @(posedge clk) begin
    // NOTE: sequential state always uses non-blocking assignments so every
    // register samples pre-edge values, whatever the statement order.
    if (!rst)                    starve_cnt <= '0;
    else if (pop || fifo_empty)  starve_cnt <= '0;
    else                         starve_cnt <= starve_cnt + SW'(1);
  end
`else
  // Without the guard the ALU always wins; the FIFO drains in ALU-idle cycles.
  assign stall = 1'b0;
`endif

  // Kill older entries aimed at the register the ALU is writing now, retire
  // the popped head, and mark the new slot live last, so a same-cycle
  // enqueue (younger than the ALU write) survives.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    kill_mask = '0;
    for (int i = 0; i < DEPTH; i++)
      kill_mask[i] = alu_issue && (ent_rd[i] == alu_rd);
    live_next = ent_live & ~kill_mask;
    if (pop)  live_next[rd_ptr] = 1'b0;
    if (push) live_next[wr_ptr] = 1'b1;
  end

  // Scoreboard query: only live entries count; x0 never reports busy.
  always_comb begin
    chk_busy = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (ent_live[i] && (ent_rd[i] == chk_addr)) chk_busy = 1'b1;
    if (chk_addr == 5'd0) chk_busy = 1'b0;
  end

  // FIFO control state: pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ent_live <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      ent_live <= live_next;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Slot payload written on enqueue.
  always_ff @(posedge clk) begin
    // NOTE: payload storage is deliberately not reset; the live bits and
    // occupancy count decide whether a slot means anything.
    if (push) begin
      ent_rd[wr_ptr]   <= lsu_rd;
      ent_data[wr_ptr] <= lsu_data;
    end
  end

  // Registered write port. Address and data hold their values when idle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      reg_write <= 1'b0;
      rd_addr   <= '0;
      rd_data   <= '0;
    end else if (alu_issue) begin
      reg_write <= 1'b1;
      rd_addr   <= alu_rd;
      rd_data   <= alu_data;
    end else if (pop && head_live) begin
      reg_write <= 1'b1;
      rd_addr   <= ent_rd[rd_ptr];
      rd_data   <= ent_data[rd_ptr];
    end else begin
      reg_write <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Bench for reg_wb_arbiter. It applies a directed vector table, then a
// starvation sequence when the guard is built in, then random stimulus
// compared against a queue-based reference model.
module tb_reg_wb_arbiter;
  localparam int XLEN         = 32;
  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 4;
`ifdef WB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            alu_valid = 1'b0, lsu_valid = 1'b0;
  logic [4:0]      alu_rd = '0, lsu_rd = '0, chk_addr = '0;
  logic [XLEN-1:0] alu_data = '0, lsu_data = '0;
  logic            lsu_ready, reg_write, chk_busy;
  logic [4:0]      rd_addr;
  logic [XLEN-1:0] rd_data;
  logic [1:0]      pend_count;
`ifdef WB_STARVE_GUARD_EN
  logic            alu_stall;
`endif

  reg_wb_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .reg_write(reg_write),
    .chk_addr(chk_addr), .chk_busy(chk_busy), .pend_count(pend_count)
`ifdef WB_STARVE_GUARD_EN
    , .alu_stall(alu_stall)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic av, input logic [4:0] ard,
                       input logic [31:0] adat, input logic lv, input logic [4:0] lrd,
                       input logic [31:0] ldat, input logic [4:0] ca);
    rst = r; alu_valid = av; alu_rd = ard; alu_data = adat;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ldat; chk_addr = ca;
  endtask

  // Directed vectors: inputs for one cycle, the combinational outputs expected
  // before the edge (if cc), and the write port expected after the edge.
  typedef struct {
    logic r; logic av; logic [4:0] ard; logic [31:0] adat;
    logic lv; logic [4:0] lrd; logic [31:0] ldat; logic [4:0] ca;
    logic cc; logic e_rdy; logic e_busy; logic [1:0] e_pend;
    logic e_we; logic [4:0] e_addr; logic [31:0] e_data;
  } vec_t;
  vec_t tbl[$];

  // Reference model: a queue of pending writes in age order.
  typedef struct { logic [4:0] rd; logic [31:0] data; bit killed; } ent_t;
  ent_t       m_q[$];
  logic       m_we;
  logic [4:0] m_addr;
  logic [31:0] m_data;
  int         m_wait;

  function automatic bit m_busy(input logic [4:0] ca);
    bit b = 0;
    foreach (m_q[i]) if (!m_q[i].killed && m_q[i].rd == ca) b = 1;
    return b && (ca != 0);
  endfunction

  function automatic bit m_stall();
    return GUARD && (m_q.size() != 0) && (m_wait >= STARVE_LIMIT);
  endfunction

  task automatic model_reset();
    m_q.delete(); m_we = 0; m_addr = 0; m_data = 0; m_wait = 0;
  endtask

  task automatic model_step(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                            input logic lv, input logic [4:0] lrd, input logic [31:0] ldat);
    bit   rdy, stl, popped, was_empty;
    ent_t e;
    rdy = m_q.size() < DEPTH;
    stl = m_stall();
    was_empty = (m_q.size() == 0);
    popped = 0;
    if (av && ard != 0 && !stl) begin
      m_we = 1; m_addr = ard; m_data = adat;
      foreach (m_q[i]) if (m_q[i].rd == ard) m_q[i].killed = 1;
    end else if (!was_empty) begin
      e = m_q.pop_front();
      popped = 1;
      m_we = !e.killed;
      if (!e.killed) begin m_addr = e.rd; m_data = e.data; end
    end else begin
      m_we = 0;
    end
    m_wait = (popped || was_empty) ? 0 : m_wait + 1;
    if (lv && rdy && lrd != 0) m_q.push_back('{rd: lrd, data: ldat, killed: 0});
  endtask

  initial begin
    // r av ard adat  lv lrd ldat  ca  cc rdy busy pend  we addr data
    tbl.push_back(vec_t'{0,0,0,0,       0,0,0,      0, 0,0,0,0, 0,0,0});
    tbl.push_back(vec_t'{0,0,0,0,       0,0,0,      0, 1,1,0,0, 0,0,0});
    tbl.push_back(vec_t'{1,1,5,'h1234,  0,0,0,      0, 1,1,0,0, 1,5,'h1234});
    tbl.push_back(vec_t'{1,0,0,0,       0,0,0,      0, 1,1,0,0, 0,5,'h1234});
    tbl.push_back(vec_t'{1,0,0,0,       1,3,'hA,    0, 1,1,0,0, 0,5,'h1234});
    tbl.push_back(vec_t'{1,0,0,0,       1,4,'hB,    3, 1,1,1,1, 1,3,'hA});
    tbl.push_back(vec_t'{1,0,0,0,       0,0,0,      4, 1,1,1,1, 1,4,'hB});
    tbl.push_back(vec_t'{1,0,0,0,       0,0,0,      4, 1,1,0,0, 0,4,'hB});
    tbl.push_back(vec_t'{1,1,10,'h100,  1,3,'hC,    4, 1,1,0,0, 1,10,'h100});
    tbl.push_back(vec_t'{1,1,11,'h101,  1,4,'hD,    4, 1,1,0,1, 1,11,'h101});
    tbl.push_back(vec_t'{1,1,12,'h102,  1,5,'hE,    4, 1,0,1,2, 1,12,'h102});
    tbl.push_back(vec_t'{1,0,0,0,       0,0,0,      3, 1,0,1,2, 1,3,'hC});
    tbl.push_back(vec_t'{1,0,0,0,       0,0,0,      4, 1,1,1,1, 1,4,'hD});
    tbl.push_back(vec_t'{1,0,0,0,       0,0,0,      0, 1,1,0,0, 0,4,'hD});
    tbl.push_back(vec_t'{1,1,20,'h200,  1,7,'h11,   0, 1,1,0,0, 1,20,'h200});
    tbl.push_back(vec_t'{1,1,7,'h22,    0,0,0,      7, 1,1,1,1, 1,7,'h22});
    tbl.push_back(vec_t'{1,0,0,0,       0,0,0,      7, 1,1,0,1, 0,7,'h22});
    tbl.push_back(vec_t'{1,0,0,0,       0,0,0,      7, 1,1,0,0, 0,7,'h22});
    tbl.push_back(vec_t'{1,1,0,'h33,    1,0,'h44,   0, 1,1,0,0, 0,7,'h22});
    tbl.push_back(vec_t'{1,0,0,0,       0,0,0,      0, 1,1,0,0, 0,7,'h22});
    tbl.push_back(vec_t'{1,1,21,'h300,  1,8,'h55,   0, 1,1,0,0, 1,21,'h300});
    tbl.push_back(vec_t'{1,1,0,'h66,    0,0,0,      8, 1,1,1,1, 1,8,'h55});
    tbl.push_back(vec_t'{1,0,0,0,       0,0,0,      8, 1,1,0,0, 0,8,'h55});
    tbl.push_back(vec_t'{1,1,22,'h400,  1,13,'h77,  0, 1,1,0,0, 1,22,'h400});
    tbl.push_back(vec_t'{1,1,23,'h401,  1,14,'h78, 14, 1,1,0,1, 1,23,'h401});
    tbl.push_back(vec_t'{0,0,0,0,       0,0,0,     13, 1,0,1,2, 0,0,0});
    tbl.push_back(vec_t'{1,0,0,0,       0,0,0,     13, 1,1,0,0, 0,0,0});
    tbl.push_back(vec_t'{1,0,0,0,       0,0,0,     13, 1,1,0,0, 0,0,0});

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].av, tbl[i].ard, tbl[i].adat,
            tbl[i].lv, tbl[i].lrd, tbl[i].ldat, tbl[i].ca);
      #1;
      if (tbl[i].cc) begin
        check($sformatf("v%0d lsu_ready", i), 32'(lsu_ready), 32'(tbl[i].e_rdy));
        check($sformatf("v%0d chk_busy", i), 32'(chk_busy), 32'(tbl[i].e_busy));
        check($sformatf("v%0d pend_count", i), 32'(pend_count), 32'(tbl[i].e_pend));
      end
      @(posedge clk); #1;
      check($sformatf("v%0d reg_write", i), 32'(reg_write), 32'(tbl[i].e_we));
      check($sformatf("v%0d rd_addr", i), 32'(rd_addr), 32'(tbl[i].e_addr));
      check($sformatf("v%0d rd_data", i), rd_data, tbl[i].e_data);
    end

`ifdef WB_STARVE_GUARD_EN
    // Starvation: one entry x9 waits behind a continuously valid ALU.
    drive(1, 1, 24, 'h600, 1, 9, 'h5, 0);
    @(posedge clk); #1;
    check("starve push write", 32'(rd_addr), 32'd24);
    for (int k = 1; k <= 6; k++) begin
      drive(1, 1, 25, 'h500, 0, 0, 0, 9);
      #1;
      check($sformatf("starve c%0d alu_stall", k), 32'(alu_stall), 32'(k == 5));
      @(posedge clk); #1;
      check($sformatf("starve c%0d reg_write", k), 32'(reg_write), 32'd1);
      check($sformatf("starve c%0d rd_addr", k), 32'(rd_addr), (k == 5) ? 32'd9 : 32'd25);
      check($sformatf("starve c%0d rd_data", k), rd_data, (k == 5) ? 32'h5 : 32'h500);
    end
`endif

    // Random phase, starting from reset so model and DUT agree.
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      logic        r, av, lv;
      logic [4:0]  ard, lrd, ca;
      logic [31:0] adat, ldat;
      r    = ($urandom_range(0, 63) != 0);
      av   = ($urandom_range(0, 99) < 55);
      lv   = ($urandom_range(0, 99) < 60);
      ard  = 5'($urandom_range(0, 7));
      lrd  = 5'($urandom_range(0, 7));
      ca   = 5'($urandom_range(0, 7));
      adat = $urandom;
      ldat = $urandom;
      drive(r, av, ard, adat, lv, lrd, ldat, ca);
      #1;
      check("rand lsu_ready", 32'(lsu_ready), 32'(m_q.size() < DEPTH));
      check("rand pend_count", 32'(pend_count), 32'(m_q.size()));
      check("rand chk_busy", 32'(chk_busy), 32'(m_busy(ca)));
`ifdef WB_STARVE_GUARD_EN
      check("rand alu_stall", 32'(alu_stall), 32'(m_stall()));
`endif
      if (!r) model_reset();
      else    model_step(av, ard, adat, lv, lrd, ldat);
      @(posedge clk); #1;
      check("rand reg_write", 32'(reg_write), 32'(m_we));
      check("rand rd_addr", 32'(rd_addr), 32'(m_addr));
      check("rand rd_data", rd_data, m_data);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reg_wb_arbiter.md
Name: reg_wb_arbiter

Overview:
Writer-side front end for the RV32I register file write port (rd_addr / rd_data / reg_write).
- Merges two writeback sources: the single-cycle ALU path and a long-latency path (loads, later mul/div).
- Buffers long-latency results in a small FIFO.
- Drives one registered write per cycle.
- Exports a pending-write scoreboard query for hazard detection.

Parameters:
XLEN, 32, data width of register writes
DEPTH, 2, long-latency pending-write FIFO entries (power of two, >=2)
STARVE_LIMIT, 4, cycles a FIFO head may wait before guard fires (only with WB_STARVE_GUARD_EN)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-low (0 = reset, sampled on rising clk)
alu_valid  in  1  ALU result present this cycle
alu_rd  in  5  ALU destination register
alu_data  in  XLEN  ALU result
lsu_valid  in  1  long-latency result offered
lsu_ready  out  1  FIFO can accept; transfer when lsu_valid && lsu_ready
lsu_rd  in  5  long-latency destination register
lsu_data  in  XLEN  long-latency result
rd_addr  out  5  register file write address (registered)
rd_data  out  XLEN  register file write data (registered)
reg_write  out  1  register file write enable (registered)
chk_addr  in  5  scoreboard query register
chk_busy  out  1  combinational: a valid FIFO entry targets chk_addr (chk_addr != 0)
pend_count  out  $clog2(DEPTH)+1  FIFO occupancy
alu_stall  out  1  only with WB_STARVE_GUARD_EN: ALU must hold its result this cycle

Behaviour:
Reset:
- While rst=0 at a rising edge: reg_write=0, rd_addr=0, rd_data=0, FIFO emptied, pend_count=0.
- All entries invalidated; starve counter cleared.
- Reset mid-operation discards buffered writes; they are never issued.

Long-latency FIFO:
- lsu_ready = (pend_count < DEPTH), computed from current occupancy only. No enqueue when full, even if a pop occurs the same cycle.
- Transfer with lsu_rd=0: accepted, not stored (dropped).
- Order is FIFO; pointers wrap modulo DEPTH.

Write arbitration, per cycle, evaluated in this order:
1. ALU issues when alu_valid=1 and alu_rd!=0 (and alu_stall=0 under the macro). Issue writes alu_rd/alu_data.
2. Otherwise, if the FIFO is non-empty, the head is popped and issued.
3. Otherwise, no write.

Issue timing:
- An issued write appears on rd_addr/rd_data with reg_write=1 in the next cycle (latency 1). The register file commits it on the following edge.
- When no write is issued, reg_write=0 next cycle; rd_addr/rd_data hold their last values.
- alu_valid with alu_rd=0: not a write. The FIFO may drain that cycle.

Ordering rules:
- The ALU is younger than every buffered entry.
- When an ALU write issues to register R, all valid FIFO entries with rd=R are killed: invalidated and later popped silently without a write. Killed entries still occupy slots until popped; pend_count counts them.
- A popped killed entry consumes its cycle with reg_write=0.
- An lsu transfer in the same cycle as an ALU write to the same R is younger: it is enqueued, not killed.

Scoreboard:
- chk_busy=1 iff some valid, non-killed entry has rd == chk_addr and chk_addr != 0.
- Same-cycle enqueue is not visible until the next cycle.

Optional Feature:
Macro WB_STARVE_GUARD_EN.
- Defined:
  - A counter tracks consecutive cycles the FIFO is non-empty and the head is not popped. It resets on a pop and on reset.
  - When the counter >= STARVE_LIMIT, alu_stall=1 combinationally and the head is issued that cycle instead of the ALU.
  - Upstream holds its ALU result while alu_stall=1; the arbiter ignores alu_valid and applies no kill that cycle.
- Undefined: the alu_stall port is absent. The ALU always wins and the FIFO drains only in ALU-idle cycles.

Test Plan:
- Reset, then alu_valid=1, rd=5, data=0x1234 -> next cycle reg_write=1, rd_addr=5, rd_data=0x1234; then alu_valid=0 -> reg_write=0.
- lsu pushes rd=3/0xA and rd=4/0xB with alu idle, DEPTH=2 -> writes x3=0xA, then x4=0xB on consecutive cycles. During a burst with alu_valid held at 1: lsu_ready=0 after 2 transfers; chk_addr=4 -> chk_busy=1.
- FIFO holds rd=7/0x11, then ALU writes rd=7/0x22 -> only x7=0x22 is issued; the later pop gives reg_write=0; chk_busy(7)=0 after the kill.
- Writes to x0 from either source -> reg_write never asserted; pend_count unchanged for the lsu rd=0 transfer.
- rst=0 asserted with 2 pending entries -> next cycle reg_write=0, pend_count=0, lsu_ready=1; the entries are never written.
- With WB_STARVE_GUARD_EN and STARVE_LIMIT=4: alu_valid held 1 and one entry rd=9/0x5 -> alu_stall=1 on the 5th cycle; x9=0x5 is issued; the ALU result is issued the following cycle.
